// File: rtl/secded_pkg.sv
// Shared types and codeword layout for the SECDED decoder (macro SECDED_STATS_EN enables error counters).
package secded_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CW_W   = 16;
    localparam int unsigned PAY_W  = 11;
    localparam int unsigned SYN_W  = 4;
    localparam int unsigned CNT_W  = 4;

    // Codeword bit positions; bit index equals Hamming position, p0 is overall parity
    localparam int unsigned POS_P0  = 0;
    localparam int unsigned POS_P1  = 1;
    localparam int unsigned POS_P2  = 2;
    localparam int unsigned POS_D1  = 3;
    localparam int unsigned POS_P4  = 4;
    localparam int unsigned POS_D2  = 5;
    localparam int unsigned POS_D4  = 7;
    localparam int unsigned POS_P8  = 8;
    localparam int unsigned POS_D5  = 9;
    localparam int unsigned POS_D11 = 15;

    typedef enum logic [1:0] {
        F_NONE   = 2'b00,
        F_SINGLE = 2'b01,
        F_DOUBLE = 2'b10
    } status_e;

    typedef enum logic [2:0] {
        IDLE,
        RD_LO,
        RD_HI,
        DECODE,
        WR_LO,
        WR_HI,
        DONE
    } state_e;

    // Gather d11..d1 out of a codeword
    function automatic logic [PAY_W-1:0] extract_payload(input logic [CW_W-1:0] cw);
        return {cw[POS_D11:POS_D5], cw[POS_D4:POS_D2], cw[POS_D1]};
    endfunction

endpackage

// File: rtl/secded_syndrome.sv
// Combinational SECDED check: syndrome, overall parity, corrected payload and status.
module secded_syndrome
    import secded_pkg::*;
(
    input  logic [CW_W-1:0]  cw,
    output logic [SYN_W-1:0] syn_c,
    output logic             parity_c,
    output logic [PAY_W-1:0] payload_c,
    output status_e          flag_c
);

    logic [SYN_W-1:0] syn;
    logic             par;
    logic [CW_W-1:0]  fixed;

    // Syndrome is the XOR of set-bit positions; odd parity means one flip at that position
    always_comb begin
        syn   = '0;
        par   = ^cw;
        fixed = cw;
        for (int unsigned k = 1; k < CW_W; k++) begin
            if (cw[k]) begin
                syn = syn ^ SYN_W'(k);
            end
        end
        flag_c = F_NONE;
        if (par) begin
            fixed[syn] = ~cw[syn];
            flag_c     = F_SINGLE;
        end else if (syn != '0) begin
            flag_c = F_DOUBLE;
        end
        syn_c     = syn;
        parity_c  = par;
        payload_c = extract_payload(fixed);
    end

endmodule

// File: rtl/secded_decoder.sv
// Walks NUM_WORDS SECDED codewords in memory, writes corrected payload plus status.
// Macro SECDED_STATS_EN adds saturating single/double error counters.
module secded_decoder
    import secded_pkg::*;
#(
    parameter int unsigned NUM_WORDS = 15,
    parameter int unsigned SRC_BASE  = 30,
    parameter int unsigned DST_BASE  = 0,
    parameter int unsigned AW        = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              ack,
    output logic [AW-1:0]     mem_addr,
    input  logic [BYTE_W-1:0] mem_rd_data,
    output logic              mem_wr_en,
    output logic [BYTE_W-1:0] mem_wr_data,
    output logic [CNT_W-1:0]  err1_cnt,
    output logic [CNT_W-1:0]  err2_cnt
);

    localparam int unsigned IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    state_e             state_q, state_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [BYTE_W-1:0]  lo_q, lo_d, hi_q, hi_d;
    logic [PAY_W-1:0]   payload_q, payload_d;
    status_e            flag_q, flag_d;
    logic               ack_q, ack_d;
    logic               armed_q, armed_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic               wr_en_q, wr_en_d;
    logic [BYTE_W-1:0]  wr_data_q, wr_data_d;

    logic [SYN_W-1:0]   syn_c;
    logic               parity_c;
    logic [PAY_W-1:0]   payload_c;
    status_e            flag_c;
    logic               start_acc_c;
    logic               unused_diag_c;

    function automatic logic [AW-1:0] word_addr(input int unsigned base,
                                                input logic [IW-1:0] idx,
                                                input logic hi);
        return AW'(base + 32'd2 * 32'(idx) + 32'(hi));
    endfunction

    secded_syndrome u_syndrome (
        .cw        ({hi_q, lo_q}),
        .syn_c     (syn_c),
        .parity_c  (parity_c),
        .payload_c (payload_c),
        .flag_c    (flag_c)
    );

    // Syndrome and parity are diagnostic only at this level
    assign unused_diag_c = ^{syn_c, parity_c};

    // armed_q blocks a start sampled on the first edge after reset release
    assign start_acc_c = (state_q == IDLE) && start && armed_q;

    // Next state, datapath latches and memory-bus outputs aligned with the next state
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        lo_d      = lo_q;
        hi_d      = hi_q;
        payload_d = payload_q;
        flag_d    = flag_q;
        ack_d     = ack_q;
        armed_d   = 1'b1;
        addr_d    = '0;
        wr_en_d   = 1'b0;
        wr_data_d = '0;

        case (state_q)
            IDLE: begin
                if (start_acc_c) begin
                    ack_d   = 1'b0;
                    idx_d   = '0;
                    state_d = RD_LO;
                end
            end
            RD_LO: begin
                lo_d    = mem_rd_data;
                state_d = RD_HI;
            end
            RD_HI: begin
                hi_d    = mem_rd_data;
                state_d = DECODE;
            end
            DECODE: begin
                payload_d = payload_c;
                flag_d    = flag_c;
                state_d   = WR_LO;
            end
            WR_LO: begin
                state_d = WR_HI;
            end
            WR_HI: begin
                if (idx_q == IW'(NUM_WORDS - 1)) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + IW'(1);
                    state_d = RD_LO;
                end
            end
            DONE: begin
                ack_d   = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        case (state_d)
            RD_LO: addr_d = word_addr(SRC_BASE, idx_d, 1'b0);
            RD_HI: addr_d = word_addr(SRC_BASE, idx_d, 1'b1);
            WR_LO: begin
                addr_d    = word_addr(DST_BASE, idx_d, 1'b0);
                wr_en_d   = 1'b1;
                wr_data_d = payload_d[BYTE_W-1:0];
            end
            WR_HI: begin
                addr_d    = word_addr(DST_BASE, idx_d, 1'b1);
                wr_en_d   = 1'b1;
                wr_data_d = {flag_d, 3'b000, payload_d[PAY_W-1:BYTE_W]};
            end
            default: begin
                addr_d = '0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            lo_q      <= '0;
            hi_q      <= '0;
            payload_q <= '0;
            flag_q    <= F_NONE;
            ack_q     <= 1'b0;
            armed_q   <= 1'b0;
            addr_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            lo_q      <= lo_d;
            hi_q      <= hi_d;
            payload_q <= payload_d;
            flag_q    <= flag_d;
            ack_q     <= ack_d;
            armed_q   <= armed_d;
            addr_q    <= addr_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign ack         = ack_q;
    assign mem_addr    = addr_q;
    assign mem_wr_en   = wr_en_q;
    assign mem_wr_data = wr_data_q;

`ifdef SECDED_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] err1_q, err1_d, err2_q, err2_d;

    // Saturating error counters, cleared by an accepted start
    always_comb begin
        err1_d = err1_q;
        err2_d = err2_q;
        if (start_acc_c) begin
            err1_d = '0;
            err2_d = '0;
        end else if (state_q == DECODE) begin
            if (flag_c == F_SINGLE && err1_q != CNT_MAX) begin
                err1_d = err1_q + CNT_W'(1);
            end
            if (flag_c == F_DOUBLE && err2_q != CNT_MAX) begin
                err2_d = err2_q + CNT_W'(1);
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err1_q <= '0;
            err2_q <= '0;
        end else begin
            err1_q <= err1_d;
            err2_q <= err2_d;
        end
    end

    assign err1_cnt = err1_q;
    assign err2_cnt = err2_q;
`else
    assign err1_cnt = '0;
    assign err2_cnt = '0;
`endif

endmodule

// File: tb/tb_secded_decoder.sv
// Self-checking bench for secded_decoder: directed vector table, random run, reset corners.
module tb_secded_decoder;

    localparam int unsigned NW  = 15;
    localparam int unsigned SRC = 30;
    localparam int unsigned DST = 0;
    localparam int unsigned AW  = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          ack;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_rd_data;
    logic          mem_wr_en;
    logic [7:0]    mem_wr_data;
    logic [3:0]    err1_cnt;
    logic [3:0]    err2_cnt;

    logic [7:0]  mem [256];
    logic [15:0] cw_arr [NW];

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;
    wr_t exp_q [$];

    typedef struct packed {
        logic [1:0] f;
        logic [7:0] hi;
        logic [7:0] lo;
    } res_t;

    typedef struct {
        logic [15:0] cw;
        logic [7:0]  hi;
        logic [7:0]  lo;
        int          e1;
        int          e2;
    } vec_t;
    vec_t vecs [4];

    secded_decoder #(
        .NUM_WORDS (NW),
        .SRC_BASE  (SRC),
        .DST_BASE  (DST),
        .AW        (AW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .ack         (ack),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_data (mem_wr_data),
        .err1_cnt    (err1_cnt),
        .err2_cnt    (err2_cnt)
    );

    always #5 clk = ~clk;

    assign mem_rd_data = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Write scoreboard, sampled mid-cycle
    always @(negedge clk) begin
        if (mem_wr_en) begin
            chk("wr range", int'(mem_addr < 8'd30), 1);
            if (exp_q.size() == 0) begin
                chk("unexpected write addr", int'(mem_addr), 255);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr addr", int'(mem_addr), int'(e.addr));
                chk("wr data", int'(mem_wr_data), int'(e.data));
            end
        end
    end

    // Reference: a word is valid when every parity group and overall parity are even
    function automatic bit cw_valid(input logic [15:0] c);
        for (int k = 0; k < 4; k++) begin
            logic x;
            x = 1'b0;
            for (int j = 1; j < 16; j++) if (((j >> k) & 1) == 1) x = x ^ c[j];
            if (x) return 1'b0;
        end
        return (^c) == 1'b0;
    endfunction

    // Reference decode by searching for a single flip that yields a valid word
    function automatic res_t model(input logic [15:0] c);
        res_t r;
        logic [15:0] fx;
        logic [10:0] d;
        fx = c;
        if (cw_valid(c)) begin
            r.f = 2'b00;
        end else begin
            r.f = 2'b10;
            for (int b = 0; b < 16; b++) begin
                logic [15:0] t;
                t = c ^ (16'h1 << b);
                if (cw_valid(t)) begin
                    fx  = t;
                    r.f = 2'b01;
                end
            end
        end
        d    = {fx[15:9], fx[7:5], fx[3]};
        r.hi = {r.f, 3'b000, d[10:8]};
        r.lo = d[7:0];
        return r;
    endfunction

    function automatic logic [15:0] encode(input logic [10:0] d);
        logic [15:0] c;
        c = '0;
        c[3] = d[0];
        c[7:5] = d[3:1];
        c[15:9] = d[10:4];
        for (int k = 0; k < 4; k++) begin
            logic x;
            x = 1'b0;
            for (int j = 1; j < 16; j++) if (((j >> k) & 1) == 1) x = x ^ c[j];
            c[1 << k] = x;
        end
        c[0] = ^c[15:1];
        return c;
    endfunction

    // Load cw_arr into memory, queue expected writes, run once, check ack timing and counters
    task automatic run_words(input bit mid_start);
        int e1;
        int e2;
        int lat;
        e1 = 0;
        e2 = 0;
        for (int i = 0; i < NW; i++) begin
            res_t r;
            mem[SRC + 2*i]     = cw_arr[i][7:0];
            mem[SRC + 2*i + 1] = cw_arr[i][15:8];
            mem[DST + 2*i]     = 8'hEE;
            mem[DST + 2*i + 1] = 8'hEE;
            r = model(cw_arr[i]);
            exp_q.push_back({8'(DST + 2*i), r.lo});
            exp_q.push_back({8'(DST + 2*i + 1), r.hi});
            if (r.f == 2'b01) e1++;
            if (r.f == 2'b10) e2++;
        end
`ifndef SECDED_STATS_EN
        e1 = 0;
        e2 = 0;
`endif
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("ack cleared on start", int'(ack), 0);
        lat = 0;
        while (!ack && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
            start = mid_start && (lat == 30);
        end
        start = 1'b0;
        chk("ack latency", lat, 76);
        chk("scoreboard drained", exp_q.size(), 0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        chk("ack held", int'(ack), 1);
        chk("err1_cnt", int'(err1_cnt), e1);
        chk("err2_cnt", int'(err2_cnt), e2);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{16'h000F, 8'h00, 8'h01, 0, 0};
        vecs[1] = '{16'h0007, 8'h40, 8'h01, 1, 0};
        vecs[2] = '{16'h000E, 8'h40, 8'h01, 1, 0};
        vecs[3] = '{16'h0027, 8'h80, 8'h02, 0, 1};
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst ack", int'(ack), 0);
        chk("rst wr_en", int'(mem_wr_en), 0);
        chk("rst addr", int'(mem_addr), 0);
        chk("rst wr_data", int'(mem_wr_data), 0);
        chk("rst err1", int'(err1_cnt), 0);
        chk("rst err2", int'(err2_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Directed vectors in word 0, clean zero codewords elsewhere
        for (int v = 0; v < 4; v++) begin
            for (int i = 0; i < NW; i++) cw_arr[i] = 16'h0000;
            cw_arr[0] = vecs[v].cw;
            run_words(1'b0);
            chk($sformatf("vec%0d hi byte", v), int'(mem[DST + 1]), int'(vecs[v].hi));
            chk($sformatf("vec%0d lo byte", v), int'(mem[DST]), int'(vecs[v].lo));
`ifdef SECDED_STATS_EN
            chk($sformatf("vec%0d err1", v), int'(err1_cnt), vecs[v].e1);
            chk($sformatf("vec%0d err2", v), int'(err2_cnt), vecs[v].e2);
`endif
        end

        // Random 15-word run with 0/1/2 flips, stray start mid-run
        for (int i = 0; i < NW; i++) begin
            logic [15:0] c;
            int nf;
            int b1;
            int b2;
            c  = encode(11'($urandom));
            nf = $urandom_range(0, 2);
            b1 = $urandom_range(0, 15);
            b2 = (b1 + $urandom_range(1, 15)) % 16;
            if (nf >= 1) c[b1] = ~c[b1];
            if (nf == 2) c[b2] = ~c[b2];
            cw_arr[i] = c;
        end
        run_words(1'b1);

        // Reset mid-run while a write is in flight
        for (int i = 0; i < NW; i++) cw_arr[i] = encode(11'($urandom));
        for (int i = 0; i < NW; i++) begin
            res_t r;
            mem[SRC + 2*i]     = cw_arr[i][7:0];
            mem[SRC + 2*i + 1] = cw_arr[i][15:8];
            r = model(cw_arr[i]);
            exp_q.push_back({8'(DST + 2*i), r.lo});
            exp_q.push_back({8'(DST + 2*i + 1), r.hi});
        end
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (18) @(posedge clk);
        #1;
        chk("wr_en before reset", int'(mem_wr_en), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid-run rst ack", int'(ack), 0);
        chk("mid-run rst wr_en", int'(mem_wr_en), 0);
        chk("mid-run rst addr", int'(mem_addr), 0);
        chk("partial word kept", int'(mem[DST + 4]), int'(model(cw_arr[2]).lo));
        exp_q.delete();
        repeat (2) @(posedge clk);

        // Start coincident with reset release is ignored
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("start at release ignored", int'(mem_addr), 0);
        repeat (2) @(posedge clk);
        #1;
        chk("still idle addr", int'(mem_addr), 0);
        chk("still idle wr_en", int'(mem_wr_en), 0);

        // Clean run after reset
        for (int i = 0; i < NW; i++) cw_arr[i] = 16'h0000;
        cw_arr[0] = vecs[0].cw;
        run_words(1'b0);
        chk("post-reset hi byte", int'(mem[DST + 1]), int'(vecs[0].hi));
        chk("post-reset lo byte", int'(mem[DST]), int'(vecs[0].lo));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
